// File: rtl/disp_pkg.sv
// Shared types and defaults for the two-digit display scan slice.
// Digit width, scan timing defaults and the scan FSM encoding.
package disp_pkg;

  localparam int DIGIT_W       = 4;
  localparam int SCAN_CYC_DEF  = 50000;
  localparam int BLANK_CYC_DEF = 500;

  typedef enum logic [2:0] {
    IDLE,
    SHOW1,
    BLANK1,
    SHOW4,
    BLANK4
  } scan_state_t;

endpackage

// File: rtl/digit_scan_ctrl_if.sv
// Control/digit bundle between game logic and the scan sequencer.
// master drives enable/load/digits, slave returns mux controls.
interface digit_scan_ctrl_if;
  import disp_pkg::*;

  logic               enable;
  logic               load;
  logic [DIGIT_W-1:0] d1_in;
  logic [DIGIT_W-1:0] d4_in;
  logic               sel;
  logic               onoff;
  logic [DIGIT_W-1:0] code_out;
  logic               load_ack;
  logic               frame_tick;

  modport master (
    output enable, load, d1_in, d4_in,
    input  sel, onoff, code_out, load_ack, frame_tick
  );

  modport slave (
    input  enable, load, d1_in, d4_in,
    output sel, onoff, code_out, load_ack, frame_tick
  );

endinterface

// File: rtl/scan_timer.sv
// Slot timer: counts 0..SCAN_CYC-1 while enabled, wraps, clears.
// wrap_o flags the last cycle of a slot.
module scan_timer
  import disp_pkg::*;
#(
  parameter  int SCAN_CYC = SCAN_CYC_DEF,
  localparam int CW       = $clog2(SCAN_CYC)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [CW-1:0] cnt_o,
  output logic          wrap_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  assign wrap_o = (cnt_q == CW'(SCAN_CYC - 1));
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i)
      cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/digit_scan_ctrl.sv
// Two-digit scan sequencer with blanking gaps and a
// frame-aligned double buffer for the digit codes.
module digit_scan_ctrl
  import disp_pkg::*;
#(
  parameter int SCAN_CYC  = SCAN_CYC_DEF,
  parameter int BLANK_CYC = BLANK_CYC_DEF
) (
  input logic               clk,
  input logic               rst_n,
  digit_scan_ctrl_if.slave  bus
);

  localparam int CW = $clog2(SCAN_CYC);
  localparam int PW = 2 * DIGIT_W;
  localparam logic [CW-1:0] SHOW_END =
    CW'(SCAN_CYC - BLANK_CYC - 1);

  scan_state_t        state_q, state_d;
  logic [CW-1:0]      cnt;
  logic               wrap;
  logic [PW-1:0]      shadow_q, shadow_d;
  logic [PW-1:0]      act_q, act_d;
  logic [PW-1:0]      load_val;
  logic               pend_q, pend_d;
  logic               sel_q, sel_d;
  logic               onoff_q, onoff_d;
  logic [DIGIT_W-1:0] code_q, code_d;
  logic               ack_q, ack_d;
  logic               tick_q, tick_d;

  scan_timer #(.SCAN_CYC(SCAN_CYC)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (state_d == IDLE),
    .en_i   ((state_q != IDLE) && bus.enable),
    .cnt_o  (cnt),
    .wrap_o (wrap)
  );

  always_comb begin
    state_d  = state_q;
    load_val = bus.load ? {bus.d1_in, bus.d4_in} : shadow_q;
    shadow_d = load_val;
    pend_d   = pend_q | bus.load;
    act_d    = act_q;
    sel_d    = sel_q;
    onoff_d  = onoff_q;
    code_d   = code_q;
    ack_d    = 1'b0;
    tick_d   = 1'b0;

    if (state_q != IDLE && !bus.enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:   if (bus.enable)      state_d = SHOW1;
        SHOW1:  if (cnt == SHOW_END) state_d = BLANK1;
        BLANK1: if (wrap)            state_d = SHOW4;
        SHOW4:  if (cnt == SHOW_END) state_d = BLANK4;
        BLANK4: if (wrap)            state_d = SHOW1;
        default:                     state_d = IDLE;
      endcase
    end

    // a load in the entry cycle itself is applied right away
    if (state_d == SHOW1 && state_q != SHOW1) begin
      tick_d = 1'b1;
      ack_d  = pend_d;
      if (pend_d) begin
        act_d  = load_val;
        pend_d = 1'b0;
      end
    end

    unique case (state_d)
      SHOW1: begin
        sel_d   = 1'b0;
        onoff_d = 1'b0;
        code_d  = act_d[PW-1 -: DIGIT_W];
      end
      SHOW4: begin
        sel_d   = 1'b1;
        onoff_d = 1'b0;
        code_d  = act_d[DIGIT_W-1:0];
      end
      BLANK1: begin
        sel_d   = 1'b0;
        onoff_d = 1'b1;
      end
      BLANK4: begin
        sel_d   = 1'b1;
        onoff_d = 1'b1;
      end
      default: begin
        sel_d   = 1'b0;
        onoff_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      act_q    <= '0;
      pend_q   <= 1'b0;
      sel_q    <= 1'b0;
      onoff_q  <= 1'b1;
      code_q   <= '0;
      ack_q    <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      act_q    <= act_d;
      pend_q   <= pend_d;
      sel_q    <= sel_d;
      onoff_q  <= onoff_d;
      code_q   <= code_d;
      ack_q    <= ack_d;
      tick_q   <= tick_d;
    end
  end

  assign bus.sel        = sel_q;
  assign bus.onoff      = onoff_q;
  assign bus.code_out   = code_q;
  assign bus.load_ack   = ack_q;
  assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Bench for digit_scan_ctrl: vector table, corner sequences and
// random traffic checked against a frame-position model.
module tb_digit_scan_ctrl;
  import disp_pkg::*;

  localparam int S = 8;
  localparam int B = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  digit_scan_ctrl_if bus();

  digit_scan_ctrl #(.SCAN_CYC(S), .BLANK_CYC(B)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int acks  = 0;
  logic prev_sel = 1'b0;
  logic prev_on  = 1'b1;

  // model: position inside a 2*S frame while running
  bit       m_run;
  int       m_pos;
  bit       m_pend;
  logic [3:0] m_sh1, m_sh4, m_a1, m_a4, m_code;
  logic     m_sel, m_on, m_ack, m_tick;

  typedef struct {
    bit r, en, ld;
    logic [3:0] a, b;
    logic sel, on;
    logic [3:0] code;
    logic ack, tick;
  } vec_t;

  vec_t tbl[26];

  function automatic vec_t mk(bit r, bit en, bit ld,
      logic [3:0] a, logic [3:0] b, logic sel, logic on,
      logic [3:0] code, logic ack, logic tick);
    vec_t v;
    v.r = r; v.en = en; v.ld = ld; v.a = a; v.b = b;
    v.sel = sel; v.on = on; v.code = code;
    v.ack = ack; v.tick = tick;
    return v;
  endfunction

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model(bit r, bit en, bit ld,
      logic [3:0] a, logic [3:0] b);
    bit enter;
    enter = 1'b0;
    if (!r) begin
      m_run = 0; m_pos = 0; m_pend = 0;
      m_sh1 = 0; m_sh4 = 0; m_a1 = 0; m_a4 = 0;
      m_sel = 0; m_on = 1; m_code = 0; m_ack = 0; m_tick = 0;
      return;
    end
    if (!m_run) begin
      if (en) begin m_run = 1; m_pos = 0; enter = 1; end
    end else if (!en) begin
      m_run = 0;
    end else begin
      m_pos = (m_pos + 1) % (2 * S);
      enter = (m_pos == 0);
    end
    if (ld) begin m_sh1 = a; m_sh4 = b; m_pend = 1; end
    m_tick = enter;
    m_ack  = enter && m_pend;
    if (m_ack) begin m_a1 = m_sh1; m_a4 = m_sh4; m_pend = 0; end
    if (m_run) begin
      m_sel = (m_pos >= S);
      m_on  = ((m_pos % S) >= S - B);
      if (!m_on) m_code = m_sel ? m_a4 : m_a1;
    end else begin
      m_sel = 0; m_on = 1;
    end
  endtask

  task automatic step(bit r, bit en, bit ld,
      logic [3:0] a, logic [3:0] b);
    rst_n = r; bus.enable = en; bus.load = ld;
    bus.d1_in = a; bus.d4_in = b;
    @(posedge clk);
    model(r, en, ld, a, b);
    #1;
    chk("sel",   bus.sel,        m_sel);
    chk("onoff", bus.onoff,      m_on);
    chk("code",  bus.code_out,   m_code);
    chk("ack",   bus.load_ack,   m_ack);
    chk("tick",  bus.frame_tick, m_tick);
    if (bus.sel !== prev_sel)
      chk("gap", prev_on | bus.onoff, 1);
    prev_sel = bus.sel;
    prev_on  = bus.onoff;
    if (bus.load_ack === 1'b1) acks++;
  endtask

  task automatic run(int n);
    for (int k = 0; k < n; k++) step(1, 1, 0, 0, 0);
  endtask

  initial begin
    int a0;
    tbl[0] = mk(0,0,0,0,0, 0,1,0,0,0);
    tbl[1] = mk(1,1,0,0,0, 0,0,0,0,1);
    for (int i = 2; i <= 6; i++)  tbl[i] = mk(1,1,0,0,0, 0,0,0,0,0);
    for (int i = 7; i <= 8; i++)  tbl[i] = mk(1,1,0,0,0, 0,1,0,0,0);
    tbl[9]  = mk(1,1,0,0,0, 1,0,0,0,0);
    tbl[10] = mk(1,1,1,3,9, 1,0,0,0,0);
    for (int i = 11; i <= 14; i++) tbl[i] = mk(1,1,0,0,0, 1,0,0,0,0);
    for (int i = 15; i <= 16; i++) tbl[i] = mk(1,1,0,0,0, 1,1,0,0,0);
    tbl[17] = mk(1,1,0,0,0, 0,0,3,1,1);
    for (int i = 18; i <= 22; i++) tbl[i] = mk(1,1,0,0,0, 0,0,3,0,0);
    for (int i = 23; i <= 24; i++) tbl[i] = mk(1,1,0,0,0, 0,1,3,0,0);
    tbl[25] = mk(1,1,0,0,0, 1,0,9,0,0);

    for (int i = 0; i < 26; i++) begin
      step(tbl[i].r, tbl[i].en, tbl[i].ld, tbl[i].a, tbl[i].b);
      chk("tbl_sel",  bus.sel,        tbl[i].sel);
      chk("tbl_on",   bus.onoff,      tbl[i].on);
      chk("tbl_code", bus.code_out,   tbl[i].code);
      chk("tbl_ack",  bus.load_ack,   tbl[i].ack);
      chk("tbl_tick", bus.frame_tick, tbl[i].tick);
    end

    // two loads in one frame: last write wins, one ack
    a0 = acks;
    step(1, 1, 1, 1, 2);
    run(1);
    step(1, 1, 1, 5, 6);
    run(5);
    chk("ll_tick", bus.frame_tick, 1);
    chk("ll_d1", bus.code_out, 5);
    run(8);
    chk("ll_d4", bus.code_out, 6);
    run(8);
    chk("ll_acks", acks - a0, 1);

    // load on the BLANK4->SHOW1 edge
    run(15);
    step(1, 1, 1, 7, 4);
    chk("edge_d1", bus.code_out, 7);
    chk("edge_ack", bus.load_ack, 1);
    chk("edge_tick", bus.frame_tick, 1);
    run(8);
    chk("edge_d4", bus.code_out, 4);

    // disable at SHOW4 count 3, pending survives
    run(1);
    step(1, 1, 1, 2, 8);
    run(1);
    step(1, 0, 0, 0, 0);
    chk("dis_on", bus.onoff, 1);
    chk("dis_sel", bus.sel, 0);
    for (int k = 0; k < 3; k++) step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    chk("ren_tick", bus.frame_tick, 1);
    chk("ren_ack", bus.load_ack, 1);
    chk("ren_code", bus.code_out, 2);
    for (int k = 0; k < 5; k++) begin
      run(1);
      chk("ren_lit", bus.onoff, 0);
    end
    run(1);
    chk("ren_blank", bus.onoff, 1);

    // reset mid-SHOW1 with pending load
    run(10);
    step(1, 1, 1, 1, 1);
    step(0, 1, 0, 0, 0);
    chk("rst_sel", bus.sel, 0);
    chk("rst_on", bus.onoff, 1);
    chk("rst_code", bus.code_out, 0);
    chk("rst_ack", bus.load_ack, 0);
    chk("rst_tick", bus.frame_tick, 0);
    step(1, 1, 0, 0, 0);
    chk("rst_ren_tick", bus.frame_tick, 1);
    a0 = acks;
    run(20);
    chk("rst_no_ack", acks - a0, 0);

    for (int k = 0; k < 600; k++) begin
      step($urandom_range(99) != 0, $urandom_range(29) != 0,
           $urandom_range(7) == 0,
           4'($urandom_range(15)), 4'($urandom_range(15)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
